// File: rtl/mdu_engine_if.sv
// Bus between the pipeline and mdu_engine: op issue, operands, stall and read-back.
interface mdu_engine_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             busy;
    logic [WIDTH-1:0] rd_data;
    logic             done;

    modport master (output flush, op, rs, rt, input busy, rd_data, done);
    modport slave  (input flush, op, rs, rt, output busy, rd_data, done);
endinterface

// File: rtl/mdu_engine.sv
// Multi-cycle HI/LO multiply/divide unit; the result is computed at acceptance and committed after a fixed latency.
// Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu (ops 9-12).
module mdu_engine #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic         clk,
    input logic         reset,
    mdu_engine_if.slave bus
);
    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,  OP_MULT = 4'd1,  OP_MULTU = 4'd2,  OP_DIV  = 4'd3,
        OP_DIVU = 4'd4,  OP_MFHI = 4'd5,  OP_MFLO  = 4'd6,  OP_MTHI = 4'd7,
        OP_MTLO = 4'd8,  OP_MADD = 4'd9,  OP_MADDU = 4'd10, OP_MSUB = 4'd11,
        OP_MSUBU = 4'd12
    } op_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, lat;
    logic [WIDTH-1:0]   hi, lo, temp_hi, temp_lo;
    logic               done_q;
    logic               start, accept, commit, idle_wr;
    logic [2*WIDTH-1:0] res, hilo, prod_s, prod_u;
    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs, b_safe, q_mag, r_mag, quo, rem;

    assign hilo   = {hi, lo};
    assign prod_s = {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} * {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt};
    assign prod_u = {{WIDTH{1'b0}}, bus.rs} * {{WIDTH{1'b0}}, bus.rt};

    // Divide via magnitudes; most-negative / -1 falls out naturally as lo=most-negative, hi=0.
    assign is_signed = (bus.op == OP_DIV);
    assign a_neg     = is_signed & bus.rs[WIDTH-1];
    assign b_neg     = is_signed & bus.rt[WIDTH-1];
    assign a_abs     = a_neg ? -bus.rs : bus.rs;
    assign b_abs     = b_neg ? -bus.rt : bus.rt;
    assign b_safe    = (bus.rt == '0) ? WIDTH'(1) : b_abs;
    assign q_mag     = a_abs / b_safe;
    assign r_mag     = a_abs % b_safe;
    assign quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem       = a_neg ? -r_mag : r_mag;

    always_comb begin
        start = 1'b0;
        res   = hilo;
        lat   = CNT_W'(MULT_CYCLES);
        case (bus.op)
            OP_MULT:  begin start = 1'b1; res = prod_s; end
            OP_MULTU: begin start = 1'b1; res = prod_u; end
            OP_DIV, OP_DIVU: begin
                start = 1'b1;
                lat   = CNT_W'(DIV_CYCLES);
                if (bus.rt != '0) res = {rem, quo};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin start = 1'b1; res = hilo + prod_s; end
            OP_MADDU: begin start = 1'b1; res = hilo + prod_u; end
            OP_MSUB:  begin start = 1'b1; res = hilo - prod_s; end
            OP_MSUBU: begin start = 1'b1; res = hilo - prod_u; end
`endif
            default: ;
        endcase
    end

    assign accept  = start && (state == IDLE) && !bus.flush;
    assign idle_wr = (state == IDLE) && !bus.flush;
    assign commit  = (state == RUN) && (cnt == CNT_W'(1));

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (commit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= commit;
            if (accept) begin
                temp_hi <= res[2*WIDTH-1:WIDTH];
                temp_lo <= res[WIDTH-1:0];
                cnt     <= lat;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi <= temp_hi;
                lo <= temp_lo;
            end else if (idle_wr && bus.op == OP_MTHI) begin
                hi <= bus.rs;
            end else if (idle_wr && bus.op == OP_MTLO) begin
                lo <= bus.rs;
            end
        end
    end

    assign bus.busy = start || (state == RUN);
    assign bus.done = done_q;

    always_comb begin
        bus.rd_data = '0;
        if (bus.op == OP_MFHI)      bus.rd_data = hi;
        else if (bus.op == OP_MFLO) bus.rd_data = lo;
    end
endmodule

// File: tb/tb_mdu_engine.sv
// Directed self-checking bench for mdu_engine at WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
module tb_mdu_engine;
    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                           OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7,
                           OP_MTLO = 4'd8, OP_MADDU = 4'd10, OP_MSUB = 4'd11;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mdu_engine_if #(.WIDTH(32)) bus ();

    mdu_engine #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        bus.op = OP_MFHI; #1 h = bus.rd_data;
        bus.op = OP_MFLO; #1 l = bus.rd_data;
        bus.op = OP_NONE;
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk); bus.op = OP_MTHI; bus.rs = h;
        @(negedge clk); bus.op = OP_MTLO; bus.rs = l;
        @(negedge clk); bus.op = OP_NONE;
    endtask

    // Issues one op for a single cycle, then samples busy/done for a bounded window after acceptance.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic busy_now, output int busy_cycles,
                          output int done_cycles, output int done_at);
        @(negedge clk);
        bus.op = o; bus.rs = a; bus.rt = b; bus.flush = 1'b0;
        #1 busy_now = bus.busy;
        @(negedge clk);
        bus.op = OP_NONE;
        busy_cycles = 0; done_cycles = 0; done_at = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                done_cycles++;
                if (done_at < 0) done_at = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.flush = 1'b0; bus.op = OP_NONE; bus.rs = '0; bus.rt = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        bus.op = OP_MFLO; #1;
        checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.rd_data); end
        bus.op = OP_NONE;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_mult();
        logic bn; int bc, dc, da; logic [31:0] h, l;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, bn, bc, dc, da);
        checks++; if (bn !== 1'b1) begin failures++; $display("FAIL mult_busy_comb got=%b exp=1", bn); end
        checks++; if (bc != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", bc); end
        checks++; if (dc != 1 || da != 5) begin failures++; $display("FAIL mult_done got=%0d@%0d exp=1@5", dc, da); end
        read_hilo(h, l);
        checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_result got=%h_%h exp=ffffffff_fffffffa", h, l); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, bc, dc, da);
        read_hilo(h, l);
        checks++; if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin failures++; $display("FAIL multu_result got=%h_%h exp=fffffffe_00000001", h, l); end
    endtask

    task automatic test_div();
        logic bn; int bc, dc, da; logic [31:0] h, l;
        write_hilo(32'h11, 32'h22);
        run_op(OP_DIVU, 32'd7, 32'd0, bn, bc, dc, da);
        checks++; if (bc != 10) begin failures++; $display("FAIL divz_busy_cycles got=%0d exp=10", bc); end
        checks++; if (dc != 1 || da != 10) begin failures++; $display("FAIL divz_done got=%0d@%0d exp=1@10", dc, da); end
        read_hilo(h, l);
        checks++; if (h !== 32'h11 || l !== 32'h22) begin failures++; $display("FAIL divz_result got=%h_%h exp=00000011_00000022", h, l); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bn, bc, dc, da);
        read_hilo(h, l);
        checks++; if (bc != 10) begin failures++; $display("FAIL divovf_busy_cycles got=%0d exp=10", bc); end
        checks++; if (h !== 32'h0 || l !== 32'h8000_0000) begin failures++; $display("FAIL divovf_result got=%h_%h exp=00000000_80000000", h, l); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, bn, bc, dc, da);
        read_hilo(h, l);
        checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_signed got=%h_%h exp=ffffffff_fffffffd", h, l); end
        run_op(OP_DIVU, 32'd100, 32'd7, bn, bc, dc, da);
        read_hilo(h, l);
        checks++; if (h !== 32'd2 || l !== 32'd14) begin failures++; $display("FAIL divu_result got=%h_%h exp=00000002_0000000e", h, l); end
    endtask

    task automatic test_flush();
        int bc, dc, da; logic [31:0] h, l;
        write_hilo(32'h0, 32'h55);
        @(negedge clk); bus.op = OP_MULT; bus.rs = 32'd6; bus.rt = 32'd7; bus.flush = 1'b0;
        @(negedge clk); bus.op = OP_MTLO; bus.rs = 32'hDEAD;
        bc = 0; dc = 0; da = -1;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) bus.flush = 1'b1;
            if (i == 2) begin bus.flush = 1'b0; bus.op = OP_NONE; end
            #1;
            if (bus.busy && i >= 2) bc++;
            if (bus.done) begin dc++; if (da < 0) da = i; end
            @(negedge clk);
        end
        checks++; if (bc != 3) begin failures++; $display("FAIL flush_busy_tail got=%0d exp=3", bc); end
        checks++; if (dc != 1 || da != 5) begin failures++; $display("FAIL flush_done got=%0d@%0d exp=1@5", dc, da); end
        read_hilo(h, l);
        checks++; if (h !== 32'h0 || l !== 32'h2A) begin failures++; $display("FAIL flush_result got=%h_%h exp=00000000_0000002a", h, l); end
        // flush in IDLE: neither a start op nor a move may take effect
        @(negedge clk); bus.flush = 1'b1; bus.op = OP_MULTU; bus.rs = 32'd3; bus.rt = 32'd3;
        @(negedge clk); bus.op = OP_MTHI; bus.rs = 32'h77;
        @(negedge clk); bus.op = OP_NONE; bus.flush = 1'b0; #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy got=%b exp=0", bus.busy); end
        read_hilo(h, l);
        checks++; if (h !== 32'h0 || l !== 32'h2A) begin failures++; $display("FAIL flush_idle_hilo got=%h_%h exp=00000000_0000002a", h, l); end
    endtask

    task automatic test_reset_mid();
        int bc, dc; logic [31:0] h, l;
        write_hilo(32'h5, 32'h6);
        @(negedge clk); bus.op = OP_DIV; bus.rs = 32'd100; bus.rt = 32'd7;
        @(negedge clk); bus.op = OP_NONE;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        read_hilo(h, l);
        checks++; if (h !== 32'h0 || l !== 32'h0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", h, l); end
        bc = 0; dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (bus.busy) bc++;
            if (bus.done) dc++;
        end
        checks++; if (bc != 0 || dc != 0) begin failures++; $display("FAIL rstmid_tail busy=%0d done=%0d exp=0/0", bc, dc); end
    endtask

    task automatic test_accumulate();
        logic bn; int bc, dc, da; logic [31:0] h, l;
        write_hilo(32'h0, 32'h1);
        run_op(OP_MSUB, 32'd1, 32'd2, bn, bc, dc, da);
        read_hilo(h, l);
`ifdef MDU_MADD_EN
        checks++; if (bn !== 1'b1 || bc != 5) begin failures++; $display("FAIL msub_busy got=%b/%0d exp=1/5", bn, bc); end
        checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFF) begin failures++; $display("FAIL msub_result got=%h_%h exp=ffffffff_ffffffff", h, l); end
        write_hilo(32'h0, 32'hFFFF_FFFF);
        run_op(OP_MADDU, 32'd1, 32'd1, bn, bc, dc, da);
        read_hilo(h, l);
        checks++; if (h !== 32'h1 || l !== 32'h0) begin failures++; $display("FAIL maddu_carry got=%h_%h exp=00000001_00000000", h, l); end
`else
        checks++; if (bn !== 1'b0 || bc != 0 || dc != 0) begin failures++; $display("FAIL msub_off busy=%b/%0d done=%0d exp=0/0/0", bn, bc, dc); end
        checks++; if (h !== 32'h0 || l !== 32'h1) begin failures++; $display("FAIL msub_off_hilo got=%h_%h exp=00000000_00000001", h, l); end
`endif
    endtask

    task automatic test_back_to_back();
        logic bn; int bc, dc, da; logic [31:0] h, l;
        run_op(4'd13, 32'd5, 32'd5, bn, bc, dc, da);
        checks++; if (bn !== 1'b0 || bc != 0) begin failures++; $display("FAIL op13_busy got=%b/%0d exp=0/0", bn, bc); end
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, bc, dc, da);
        run_op(OP_DIVU, 32'd9, 32'd4, bn, bc, dc, da);
        read_hilo(h, l);
        checks++; if (h !== 32'd1 || l !== 32'd2 || dc != 1) begin failures++; $display("FAIL b2b_divu got=%h_%h done=%0d exp=00000001_00000002 1", h, l, dc); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid();
        test_accumulate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
